// File: rtl/eeprom_word_fifo_if.sv
// Handshake bundle between the SPI EEPROM controller, the word FIFO and the
// downstream word consumer.
interface eeprom_word_fifo_if #(
    parameter int DEPTH = 4
);
    logic                     IN_clear;
    logic                     IN_data;
    logic                     IN_dataValid;
    logic                     IN_dataByte;
    logic                     IN_dataWord;
    logic                     IN_ready;
    logic [31:0]              OUT_word;
    logic                     OUT_valid;
    logic [$clog2(DEPTH):0]   OUT_count;
    logic [31:0]              OUT_sum;
    logic                     OUT_overflow;
    logic                     OUT_frameErr;

    // Producer / consumer side (drives the serial stream and the ready)
    modport master (
        output IN_clear, IN_data, IN_dataValid, IN_dataByte, IN_dataWord, IN_ready,
        input  OUT_word, OUT_valid, OUT_count, OUT_sum, OUT_overflow, OUT_frameErr
    );

    // FIFO side
    modport slave (
        input  IN_clear, IN_data, IN_dataValid, IN_dataByte, IN_dataWord, IN_ready,
        output OUT_word, OUT_valid, OUT_count, OUT_sum, OUT_overflow, OUT_frameErr
    );
endinterface

// File: rtl/eeprom_word_fifo.sv
// Serial-to-word deserialiser with a small circular FIFO, running word sum
// and sticky framing/overflow flags.
module eeprom_word_fifo #(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    eeprom_word_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    // Only the low 31 bits of the shift register ever reach a completed word,
    // so the oldest bit is not stored.
    logic [30:0] sr;
    logic [5:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] sum;
    logic        overflow;
    logic        frame_err;

    logic [31:0] word_val;
    logic [2:0]  byte_incl;
    logic        frame_ok;
    logic        push_req;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_ok;

    // Word assembly, framing check and FIFO push/pop decisions
    always_comb begin
        word_val  = {sr, bus.IN_data};
        byte_incl = byte_cnt;
        if (bus.IN_dataByte && byte_cnt != 3'd7) begin
            byte_incl = byte_cnt + 3'd1;
        end
        frame_ok = (bit_cnt == 6'd31) && (byte_incl == 3'd4);
        push_req = bus.IN_dataValid && bus.IN_dataWord;
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop      = !empty && bus.IN_ready;
        // A full FIFO still takes the word when the head leaves this cycle.
        push_ok  = push_req && (!full || pop);
    end

    // Shift register and bit/byte counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr       <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (bus.IN_clear) begin
            sr       <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (bus.IN_dataValid) begin
            sr <= word_val[30:0];
            if (bus.IN_dataWord) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else begin
                if (bit_cnt != 6'd32) begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
                byte_cnt <= byte_incl;
            end
        end
    end

    // FIFO storage and pointers; storage is zeroed so the head reads 0 after flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.IN_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= word_val;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Running sum of accepted words and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum       <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else if (bus.IN_clear) begin
            sum       <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else if (push_req) begin
            if (push_ok) begin
                sum <= sum + word_val;
            end else begin
                overflow <= 1'b1;
            end
            if (!frame_ok) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign bus.OUT_word     = mem[rd_ptr[AW-1:0]];
    assign bus.OUT_valid    = !empty;
    assign bus.OUT_count    = wr_ptr - rd_ptr;
    assign bus.OUT_sum      = sum;
    assign bus.OUT_overflow = overflow;
    assign bus.OUT_frameErr = frame_err;
endmodule

// File: doc/eeprom_word_fifo.md
# eeprom_word_fifo

- Deserialises the bit stream from the SPI EEPROM controller into 32-bit words and buffers them in a small FIFO with a valid/ready output handshake.
- Keeps a running 32-bit sum of accepted words and reports framing and overflow errors.
- Sits directly downstream of the SPI EEPROM controller, replacing ad-hoc shift/accumulate logic in the top level.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- IN_clear  in  1  synchronous flush: empties FIFO, clears shift state, sum and sticky flags.
- IN_data  in  1  serial bit from controller, MSB-first.
- IN_dataValid  in  1  IN_data valid this cycle.
- IN_dataByte  in  1  qualified by IN_dataValid; this bit completes a byte.
- IN_dataWord  in  1  qualified by IN_dataValid; this bit completes a 32-bit word.
- OUT_word  out  32  FIFO head word.
- OUT_valid  out  1  FIFO non-empty.
- IN_ready  in  1  consumer accepts head when OUT_valid & IN_ready.
- OUT_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- OUT_sum  out  32  sum of all words pushed into FIFO, mod 2^32.
- OUT_overflow  out  1  sticky: a completed word was dropped.
- OUT_frameErr  out  1  sticky: word flag arrived with byte count ≠ 4 or bit count ≠ 32.

## Operation
- Shift register: on IN_dataValid, sr <= {sr[30:0], IN_data}; completed word value = {sr[30:0], IN_data} (includes current bit).
- Bit counter (0..32, saturating at 32) increments per valid bit.
- Byte counter (0..7, saturating) increments on valid & IN_dataByte, including the word-flag bit.
- On valid & IN_dataWord:
  - push the completed word;
  - check: bits including this one = 32 and bytes including this one = 4; else set OUT_frameErr (word still pushed);
  - reset bit and byte counters to 0; sr itself is not cleared.
- Push:
  - accepted if not full, or if full and a pop occurs the same cycle;
  - else word dropped, OUT_overflow set, OUT_sum unchanged.
- Accepted push: OUT_sum <= OUT_sum + word (wraps).
- Pop: OUT_valid & IN_ready advances read pointer. IN_ready while empty has no effect.
- FIFO: circular buffer, read/write pointers with an extra wrap bit. Pointers wrap modulo DEPTH. Full when pointers differ only in the wrap bit.
- IN_clear has priority over a same-cycle push, pop or bit. All of that cycle's input is discarded.
- Reset values: OUT_valid 0, OUT_count 0, OUT_sum 0, OUT_overflow 0, OUT_frameErr 0, OUT_word 0 (storage cleared), counters and sr 0.
- Reset asserted mid-word or mid-transfer returns immediately to reset values; the partial word is lost.

## Timing
- Word flag in cycle N → OUT_valid = 1 and OUT_word valid from cycle N+1 (one-cycle latency when FIFO empty).
- OUT_sum updates in cycle N+1.
- Pop in cycle M → next head (or OUT_valid = 0) visible in cycle M+1.
- OUT_word and OUT_valid are driven from registers only; no combinational path from IN_ready.
- Simultaneous push and pop on a non-empty FIFO: OUT_count unchanged.
- Simultaneous push and pop on an empty FIFO: the pop is not possible (OUT_valid = 0), so count becomes 1.
- Full FIFO with same-cycle pop: push accepted, count stays DEPTH, no overflow.
- Throughput: one push per cycle and one pop per cycle sustained.
- Sticky flags set in the cycle after the offending event. They clear only on rst or IN_clear.

## Test plan
- Single word: serialise 0xDEADBEEF (byte flags on bits 8/16/24/32, word flag on bit 32), IN_ready = 0 → cycle after flag: OUT_valid = 1, OUT_word = 0xDEADBEEF, OUT_count = 1, OUT_sum = 0xDEADBEEF, no flags.
- Fill/overflow (DEPTH = 4), IN_ready = 0: push words 1, 2, 3, 4, 5 → OUT_count = 4, OUT_overflow = 1, OUT_sum = 10. Then drain with IN_ready = 1 → pops return 1, 2, 3, 4, then OUT_valid = 0.
- Full with same-cycle pop: FIFO holds 1..4, word 5 completes while IN_ready = 1 → no overflow, OUT_count = 4, subsequent pops return 2, 3, 4, 5.
- Sum wrap: push 0xFFFFFFFF then 0x00000002 → OUT_sum = 0x00000001.
- Framing: word flag after 16 bits / 2 byte flags, value 0x1234 → OUT_frameErr = 1, OUT_word = 0x????1234 (upper bits from prior sr). Next well-formed word is pushed normally; OUT_frameErr stays 1 until IN_clear.
- Reset/clear mid-operation: assert rst after 20 bits with 2 words queued → all outputs 0 immediately. A full 32-bit word sent afterwards is delivered correctly with no frameErr. Repeat using IN_clear in place of rst, with the same result.
